// File: rtl/reaction_pkg.sv
// Shared state encoding, LFSR constants and default timing for the reaction timer.
// Declarations only: no latency, no backpressure.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int LFSR_W = 8;
  // Fibonacci taps 8,6,5,4 -> register bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_MIN_DELAY_TICKS = 100;
  localparam int DEF_TIMEOUT_TICKS   = 99;

  localparam int DELAY_W    = 11;
  localparam int TICK_CNT_W = 10;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer plus falling-edge detect for an active-low button pin.
// Latency: press is high in the cycle after the 2nd edge past the pin fall; no backpressure.
module button_sync (
  input  logic Clock,
  input  logic Resetn,
  input  logic pin_n,
  output logic press
);

  // sync[0], sync[1] synchronize; sync[2] is the edge-detect history flop
  logic [2:0] sync;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], pin_n};
    end
  end

  assign press = sync[2] & ~sync[1];

endmodule

// File: rtl/reaction_control.sv
// Reaction-timer controller: random delay, armed LED, push timing, false-start and timeout.
// Latency: button presses act on the 3rd edge after the pin falls; no backpressure.
module reaction_control
  import reaction_pkg::*;
#(
  parameter int                MIN_DELAY_TICKS = DEF_MIN_DELAY_TICKS,
  parameter int                TIMEOUT_TICKS   = DEF_TIMEOUT_TICKS,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 8'h01
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Tick,
  input  logic       Startn,
  input  logic       Pushn,
  output logic       LEDn,
  output logic       CountEn,
  output logic       CountClr,
  output logic       FalseStart,
  output logic       Timeout,
  output logic [2:0] State
);

  localparam logic [TICK_CNT_W-1:0] TICK_MAX = '1;

  state_t                  state, state_n;
  logic [LFSR_W-1:0]       lfsr;
  logic [DELAY_W-1:0]      delay_cnt, delay_n;
  logic [TICK_CNT_W-1:0]   tick_cnt, tick_n, tick_inc;
  logic                    to_flag, to_n;
  logic                    start_press, push_press, clr;

  button_sync u_start_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .pin_n  (Startn),
    .press  (start_press)
  );

  button_sync u_push_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .pin_n  (Pushn),
    .press  (push_press)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_SEED;
      delay_cnt <= '0;
      tick_cnt  <= '0;
      to_flag   <= 1'b0;
    end else begin
      state     <= state_n;
      // recover from an all-zero lock-up rather than sticking there
      lfsr      <= (lfsr == '0) ? LFSR_SEED : lfsr_step(lfsr);
      delay_cnt <= delay_n;
      tick_cnt  <= tick_n;
      to_flag   <= to_n;
    end
  end

  assign tick_inc = (tick_cnt == TICK_MAX) ? tick_cnt : tick_cnt + 1'b1;

  always_comb begin
    state_n = state;
    delay_n = delay_cnt;
    tick_n  = tick_cnt;
    to_n    = to_flag;
    clr     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start_press) begin
          state_n = ST_WAIT;
          clr     = 1'b1;
          delay_n = DELAY_W'(MIN_DELAY_TICKS) + DELAY_W'(lfsr);
          tick_n  = '0;
          to_n    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (push_press) begin
          state_n = ST_FAULT;
        end else if (Tick) begin
          delay_n = delay_cnt - 1'b1;
          if (delay_cnt == DELAY_W'(1)) begin
            state_n = ST_ARMED;
            tick_n  = '0;
          end
        end
      end
      ST_ARMED: begin
        if (Tick) begin
          tick_n = tick_inc;
        end
        // a push wins over the timeout Tick landing in the same cycle
        if (push_press) begin
          state_n = ST_DONE;
          to_n    = 1'b0;
        end else if (Tick && (int'(tick_inc) >= TIMEOUT_TICKS)) begin
          state_n = ST_DONE;
          to_n    = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign State      = state;
  assign LEDn       = (state != ST_ARMED);
  assign CountEn    = Resetn && (state == ST_ARMED) && Tick;
  assign CountClr   = Resetn && clr;
  assign FalseStart = (state == ST_FAULT);
  assign Timeout    = (state == ST_DONE) && to_flag;

endmodule

// File: tb/tb_reaction_control.sv
// Bench for reaction_control: table of runs with a scoreboard queue plus hand-written corner sequences.
// Two instances share the stimulus: dut_a with the default timeout, dut_b with a 5-tick timeout.
module tb_reaction_control;

  localparam int         MIN_D = 4;
  localparam logic [7:0] SEED  = 8'h01;

  logic       Clock = 1'b0;
  logic       Resetn, Tick, Startn, Pushn;
  logic [1:0] ledn, cen, cclr, fs, tmo;
  logic [2:0] st [2];

  always #5 Clock = ~Clock;

  reaction_control #(.MIN_DELAY_TICKS(MIN_D), .TIMEOUT_TICKS(99), .LFSR_SEED(SEED)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .Tick(Tick), .Startn(Startn), .Pushn(Pushn),
    .LEDn(ledn[0]), .CountEn(cen[0]), .CountClr(cclr[0]), .FalseStart(fs[0]),
    .Timeout(tmo[0]), .State(st[0])
  );

  reaction_control #(.MIN_DELAY_TICKS(MIN_D), .TIMEOUT_TICKS(5), .LFSR_SEED(SEED)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .Tick(Tick), .Startn(Startn), .Pushn(Pushn),
    .LEDn(ledn[1]), .CountEn(cen[1]), .CountClr(cclr[1]), .FalseStart(fs[1]),
    .Timeout(tmo[1]), .State(st[1])
  );

  typedef struct {
    string name;
    int    sel;
    int    push_after;
    bit    wait_push;
    int    exp_st;
    int    exp_pulses;
    int    exp_to;
    int    exp_fs;
  } vec_t;

  typedef struct {
    string name;
    int    st;
    int    pulses;
    int    to;
    int    fs;
    int    arm;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  int         tick_div = 0;
  logic [7:0] lfsr_m = SEED;
  int         pulses [2];
  int         clrs   [2];
  logic [2:0] s_st   [2];
  logic [1:0] s_ledn, s_fs, s_tmo;
  logic       s_tick;
  logic [7:0] s_lfsr;
  exp_t       exp_q [$];
  vec_t       vecs  [6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample mid-cycle, cross one rising edge, then update the bench-side LFSR and Tick.
  task automatic step();
    #4;
    for (int i = 0; i < 2; i++) begin
      s_st[i]   = st[i];
      pulses[i] += int'(cen[i]);
      clrs[i]   += int'(cclr[i]);
    end
    s_ledn = ledn;
    s_fs   = fs;
    s_tmo  = tmo;
    s_tick = Tick;
    s_lfsr = lfsr_m;
    @(posedge Clock);
    #1;
    lfsr_m   = !Resetn ? SEED : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    tick_div = (tick_div == 9) ? 0 : tick_div + 1;
    Tick     = (tick_div == 9);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      pulses[i] = 0;
      clrs[i]   = 0;
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Startn = 1'b1;
    Pushn  = 1'b1;
    repeat (3) step();
    Resetn = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   sel;
    int   n;
    int   ticks;
    int   arm_ticks;
    bit   armed;
    bit   pushed;
    sel       = v.sel;
    ticks     = 0;
    arm_ticks = -1;
    armed     = 1'b0;
    pushed    = 1'b0;
    do_reset();
    repeat (1 + (idx * 53) % 97) step();
    clear_counts();
    Startn = 1'b0;
    n = 0;
    while (clrs[sel] == 0 && n < 20) begin
      step();
      n++;
    end
    check({v.name, "_start_latency"}, n, 3);
    check({v.name, "_start_clr"}, clrs[sel], 1);
    Startn   = 1'b1;
    e.name   = v.name;
    e.st     = v.exp_st;
    e.pulses = v.exp_pulses;
    e.to     = v.exp_to;
    e.fs     = v.exp_fs;
    e.arm    = MIN_D + int'(s_lfsr);
    exp_q.push_back(e);

    if (v.wait_push) begin
      Pushn = 1'b0;
      repeat (3) step();
      check({v.name, "_fault_not_early"}, int'(s_st[sel]), 1);
      step();
    end

    n = 0;
    while (n < 4000) begin
      if (s_st[sel] == 3'd3 || s_st[sel] == 3'd4) break;
      if (v.push_after >= 0 && !pushed && pulses[sel] == v.push_after) begin
        Pushn  = 1'b0;
        pushed = 1'b1;
      end
      step();
      n++;
      if (!armed) begin
        if (s_ledn[sel] == 1'b0) begin
          armed     = 1'b1;
          arm_ticks = ticks;
        end else if (s_tick) begin
          ticks++;
        end
      end
    end

    e = exp_q.pop_front();
    check({e.name, "_state"},  int'(s_st[sel]),   e.st);
    check({e.name, "_pulses"}, pulses[sel],        e.pulses);
    check({e.name, "_timeout"}, int'(s_tmo[sel]), e.to);
    check({e.name, "_falsestart"}, int'(s_fs[sel]), e.fs);
    check({e.name, "_ledn"},   int'(s_ledn[sel]), 1);
    if (e.fs == 0) check({e.name, "_arm_tick"}, arm_ticks, e.arm);

    Pushn = 1'b1;
    clear_counts();
    Startn = 1'b0;
    repeat (8) step();
    check({v.name, "_restart_clr"},   clrs[sel], 1);
    check({v.name, "_restart_state"}, int'(s_st[sel]), 1);
    Startn = 1'b1;
  endtask

  initial begin
    int n;
    Tick   = 1'b0;
    Resetn = 1'b0;
    Startn = 1'b1;
    Pushn  = 1'b1;

    vecs[0] = '{"run7",    0,  7, 1'b0, 3, 7, 0, 0};
    vecs[1] = '{"run1",    0,  1, 1'b0, 3, 1, 0, 0};
    vecs[2] = '{"false_a", 0, -1, 1'b1, 4, 0, 0, 1};
    vecs[3] = '{"tmo_b",   1, -1, 1'b0, 3, 5, 1, 0};
    vecs[4] = '{"run3_b",  1,  3, 1'b0, 3, 3, 0, 0};
    vecs[5] = '{"false_b", 1, -1, 1'b1, 4, 0, 0, 1};

    // reset values as seen while Resetn is held low
    do_reset();
    check("rst_state",      int'(s_st[0]),   0);
    check("rst_ledn",       int'(s_ledn[0]), 1);
    check("rst_counten",    pulses[0],       0);
    check("rst_countclr",   clrs[0],         0);
    check("rst_falsestart", int'(s_fs[0]),   0);
    check("rst_timeout",    int'(s_tmo[0]),  0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // push press lands on the same cycle as the 5th (timeout) Tick
    do_reset();
    clear_counts();
    Startn = 1'b0;
    repeat (4) step();
    Startn = 1'b1;
    n = 0;
    while (pulses[1] < 4 && n < 4000) begin
      step();
      n++;
    end
    n = 0;
    while (tick_div != 7 && n < 20) begin
      step();
      n++;
    end
    Pushn = 1'b0;
    repeat (4) step();
    check("sim_state",   int'(s_st[1]),  3);
    check("sim_timeout", int'(s_tmo[1]), 0);
    check("sim_pulses",  pulses[1],      5);
    Pushn = 1'b1;

    // one-cycle reset while ARMED, aligned with a Tick
    do_reset();
    Startn = 1'b0;
    repeat (4) step();
    Startn = 1'b1;
    n = 0;
    while (s_ledn[0] != 1'b0 && n < 4000) begin
      step();
      n++;
    end
    repeat (12) step();
    n = 0;
    while (!Tick && n < 12) begin
      step();
      n++;
    end
    check("rst_mid_armed_ledn", int'(s_ledn[0]), 0);
    clear_counts();
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    step();
    check("rst_mid_state", int'(s_st[0]),   0);
    check("rst_mid_ledn",  int'(s_ledn[0]), 1);
    repeat (4) step();
    check("rst_mid_no_clr", clrs[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
